// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants and types: default register width, register
// count and the register-address type used by decode, issue and the ALU.
package cpu_pkg;
  localparam int REG_W_DEF = 8;
  localparam int REG_NUM   = 4;
  localparam int REG_AW    = $clog2(REG_NUM);

  typedef logic [REG_AW-1:0] reg_addr_t;
endpackage

// File: rtl/wr_arbiter.sv
// Fixed-priority write arbiter: for one target address, reports whether any
// enabled write port hits it and returns the highest-index port's data.
module wr_arbiter #(
  parameter int W  = 8,
  parameter int AW = 2,
  parameter int NW = 3
) (
  input  logic [NW-1:0]    we,
  input  logic [NW*AW-1:0] waddr,
  input  logic [NW*W-1:0]  wdata,
  input  logic [AW-1:0]    addr,
  output logic             hit,
  output logic [W-1:0]     data
);

  // Ascending scan so a later (higher-index) match overrides earlier ones.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    for (int i = 0; i < NW; i++) begin
      if (we[i] && (waddr[i*AW +: AW] == addr)) begin
        hit  = 1'b1;
        data = wdata[i*W +: W];
      end
    end
  end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file with fixed-priority writes, optional write-to-read
// bypass and a per-register busy scoreboard for RAW stalls at issue.
module reg_file_mp
  import cpu_pkg::*;
#(
  parameter int W       = REG_W_DEF,
  parameter int NREG    = REG_NUM,
  parameter int NW      = 3,
  parameter int NR      = 3,
  parameter int BYPASS  = 1,
  parameter int R0_ZERO = 0,
  localparam int AW     = $clog2(NREG)
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [NW-1:0]     WE,
  input  logic [NW*AW-1:0]  WADDR,
  input  logic [NW*W-1:0]   WDATA,
  input  logic [NR*AW-1:0]  RADDR,
  output logic [NR*W-1:0]   RDATA,
  input  logic              LOCK_EN,
  input  logic [AW-1:0]     LOCK_ADDR,
  output logic [NREG-1:0]   BUSY,
  output logic [NREG*W-1:0] REGS
);

  logic [W-1:0] regs_c [NREG];

  for (genvar r = 0; r < NREG; r++) begin : g_reg
    localparam bit HARD0 = (R0_ZERO != 0) && (r == 0);

    logic         hit;
    logic [W-1:0] wr_data;
    logic         lock_set;
    logic [W-1:0] reg_q;
    logic         busy_q;

    wr_arbiter #(.W(W), .AW(AW), .NW(NW)) u_commit_arb (
      .we    (WE),
      .waddr (WADDR),
      .wdata (WDATA),
      .addr  (AW'(r)),
      .hit   (hit),
      .data  (wr_data)
    );

    assign lock_set = LOCK_EN && (LOCK_ADDR == AW'(r)) && !HARD0;

    // A lock in the same cycle as a write wins: the new issuer owns the register.
    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        reg_q  <= '0;
        busy_q <= 1'b0;
      end else begin
        if (hit && !HARD0) reg_q <= wr_data;
        if (lock_set)      busy_q <= 1'b1;
        else if (hit)      busy_q <= 1'b0;
      end
    end

    assign regs_c[r]      = reg_q;
    assign BUSY[r]        = busy_q;
    assign REGS[r*W +: W] = reg_q;
  end

  for (genvar j = 0; j < NR; j++) begin : g_rd
    logic [AW-1:0] ra;
    logic          hit;
    logic [W-1:0]  byp_data;
    logic [W-1:0]  rd;

    assign ra = RADDR[j*AW +: AW];

    wr_arbiter #(.W(W), .AW(AW), .NW(NW)) u_bypass_arb (
      .we    (WE),
      .waddr (WADDR),
      .wdata (WDATA),
      .addr  (ra),
      .hit   (hit),
      .data  (byp_data)
    );

    // Hardwired zero must also mask the bypass path.
    always_comb begin
      rd = regs_c[ra];
      if ((BYPASS != 0) && hit) rd = byp_data;
      if ((R0_ZERO != 0) && (ra == '0)) rd = '0;
    end

    assign RDATA[j*W +: W] = rd;
  end

endmodule
